// File: rtl/lcd_timing_gen.sv
`timescale 1ns/1ps
// lcd_timing_gen
// ----------------------------------------------------------------------------
// Raster timing generator for a 480x272 RGB565 panel in the pixel clock domain.
// It issues lookahead pixel requests (req_x, req_y, req_valid) to an upstream
// pixel source. It takes that source's RGB back LATENCY cycles later and drives
// the panel DE/HSYNC/VSYNC/RGB with all of them aligned.
//
// Ports
//   PixelClk              pixel clock; the only clock
//   nRST                  synchronous active-low reset
//   req_valid             request refers to a visible pixel
//   req_x [9:0]           requested column (holds hcnt even when not valid)
//   req_y [8:0]           requested row    (holds vcnt even when not valid)
//   line_start            pulse with the req_x=0 request of each active line
//   frame_start           pulse with the (0,0) request
//   pix_r/pix_g/pix_b     upstream RGB565, due LATENCY-1 cycles after request
//   LCD_DE                data enable
//   LCD_HSYNC, LCD_VSYNC  active-low syncs
//   LCD_R/LCD_G/LCD_B     panel RGB, zero whenever LCD_DE is low
//
// Build option
//   LCD_TIMING_TEST_PATTERN_EN  when defined, pix_* are ignored. Eight
//   60-pixel colour bars (white, yellow, cyan, green, magenta, red, blue,
//   black) are generated from the delayed column instead.
//
// LATENCY must lie in 1..8.
// ----------------------------------------------------------------------------
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 39,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 8,
  parameter int LATENCY  = 2
) (
  input  logic       PixelClk,
  input  logic       nRST,
  output logic       req_valid,
  output logic [9:0] req_x,
  output logic [8:0] req_y,
  output logic       line_start,
  output logic       frame_start,
  input  logic [4:0] pix_r,
  input  logic [5:0] pix_g,
  input  logic [4:0] pix_b,
  output logic       LCD_DE,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Phase boundaries expressed as the first count of each phase.
  localparam logic [9:0] H_FRONT_START = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_START  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
  localparam logic [8:0] V_FRONT_START = 9'(V_ACTIVE);
  localparam logic [8:0] V_SYNC_START  = 9'(V_ACTIVE + V_FP);
  localparam logic [8:0] V_BACK_START  = 9'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [8:0] V_LAST        = 9'(V_TOTAL - 1);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  // ---------------------------------------------------------------- counters
  logic [9:0] hcnt_reg, hcnt_next;
  logic [8:0] vcnt_reg, vcnt_next;
  logic       h_wrap;
  phase_t     h_phase_reg, h_phase_next;
  phase_t     v_phase_reg, v_phase_next;

  always_comb begin
    h_wrap    = (hcnt_reg == H_LAST);
    hcnt_next = h_wrap ? 10'd0 : hcnt_reg + 10'd1;
    vcnt_next = vcnt_reg;
    if (h_wrap) begin
      vcnt_next = (vcnt_reg == V_LAST) ? 9'd0 : vcnt_reg + 9'd1;
    end
  end

  // Phase FSMs track the counter values they will hold after this edge, so
  // the registered phase always describes the registered count.
  always_comb begin
    h_phase_next = h_phase_reg;
    case (h_phase_reg)
      PH_ACTIVE: if (hcnt_next == H_FRONT_START) h_phase_next = PH_FRONT;
      PH_FRONT:  if (hcnt_next == H_SYNC_START)  h_phase_next = PH_SYNC;
      PH_SYNC:   if (hcnt_next == H_BACK_START)  h_phase_next = PH_BACK;
      PH_BACK:   if (hcnt_next == 10'd0)         h_phase_next = PH_ACTIVE;
      default:   h_phase_next = PH_ACTIVE;
    endcase
  end

  always_comb begin
    v_phase_next = v_phase_reg;
    if (h_wrap) begin
      case (v_phase_reg)
        PH_ACTIVE: if (vcnt_next == V_FRONT_START) v_phase_next = PH_FRONT;
        PH_FRONT:  if (vcnt_next == V_SYNC_START)  v_phase_next = PH_SYNC;
        PH_SYNC:   if (vcnt_next == V_BACK_START)  v_phase_next = PH_BACK;
        PH_BACK:   if (vcnt_next == 9'd0)          v_phase_next = PH_ACTIVE;
        default:   v_phase_next = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      hcnt_reg    <= 10'd0;
      vcnt_reg    <= 9'd0;
      h_phase_reg <= PH_ACTIVE;
      v_phase_reg <= PH_ACTIVE;
    end else begin
      hcnt_reg    <= hcnt_next;
      vcnt_reg    <= vcnt_next;
      h_phase_reg <= h_phase_next;
      v_phase_reg <= v_phase_next;
    end
  end

  // ------------------------------------------------------- request stage
  logic hsync_raw_reg, vsync_raw_reg;

  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      req_valid     <= 1'b0;
      req_x         <= 10'd0;
      req_y         <= 9'd0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      hsync_raw_reg <= 1'b1;
      vsync_raw_reg <= 1'b1;
    end else begin
      req_valid     <= (h_phase_reg == PH_ACTIVE) && (v_phase_reg == PH_ACTIVE);
      req_x         <= hcnt_reg;
      req_y         <= vcnt_reg;
      line_start    <= (hcnt_reg == 10'd0) && (v_phase_reg == PH_ACTIVE);
      frame_start   <= (hcnt_reg == 10'd0) && (vcnt_reg == 9'd0);
      hsync_raw_reg <= (h_phase_reg != PH_SYNC);
      vsync_raw_reg <= (v_phase_reg != PH_SYNC);
    end
  end

  // ------------------------------------------------------ delay pipeline
  // Everything that has to stay aligned with the returned pixel travels
  // together. The column is only carried when the bars need it.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
`ifdef LCD_TIMING_TEST_PATTERN_EN
    logic [9:0] x;
`endif
  } tap_t;

`ifdef LCD_TIMING_TEST_PATTERN_EN
  localparam tap_t TAP_IDLE = tap_t'({3'b011, 10'd0});
`else
  localparam tap_t TAP_IDLE = tap_t'(3'b011);
`endif

  tap_t tap_in;
  tap_t tap_out;
  logic pre_de;

  always_comb begin
    tap_in    = TAP_IDLE;
    tap_in.de = req_valid;
    tap_in.hs = hsync_raw_reg;
    tap_in.vs = vsync_raw_reg;
`ifdef LCD_TIMING_TEST_PATTERN_EN
    tap_in.x  = req_x;
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_dly
      tap_t q;
      tap_t d;
      if (gi == 0) begin : g_head
        assign d = tap_in;
      end else begin : g_tail
        assign d = g_dly[gi-1].q;
      end
      always_ff @(posedge PixelClk) begin
        if (!nRST) q <= TAP_IDLE;
        else       q <= d;
      end
    end
  endgenerate

  assign tap_out = g_dly[LATENCY-1].q;

  // The RGB register loads on the same edge as the final stage. It therefore
  // has to look one stage earlier, which is the request itself when
  // LATENCY is 1.
`ifdef LCD_TIMING_TEST_PATTERN_EN
  logic [9:0] pre_x;
`endif
  generate
    if (LATENCY == 1) begin : g_pre_req
      assign pre_de = tap_in.de;
`ifdef LCD_TIMING_TEST_PATTERN_EN
      assign pre_x  = tap_in.x;
`endif
    end else begin : g_pre_dly
      assign pre_de = g_dly[LATENCY-2].q.de;
`ifdef LCD_TIMING_TEST_PATTERN_EN
      assign pre_x  = g_dly[LATENCY-2].q.x;
`endif
    end
  endgenerate

  // ------------------------------------------------------- pixel source
  logic [15:0] rgb_src;
  logic [15:0] rgb_reg;

`ifdef LCD_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_idx;
  logic       unused_tail;

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (pre_x >= 10'(BAR_W * k)) bar_idx = 3'(k);
    end
  end

  // The bar order is a 3-bit count with red = !b1, green = !b2, blue = !b0.
  assign rgb_src     = {{5{~bar_idx[1]}}, {6{~bar_idx[2]}}, {5{~bar_idx[0]}}};
  assign unused_tail = ^{pix_r, pix_g, pix_b, tap_out.x};
`else
  assign rgb_src = {pix_r, pix_g, pix_b};
`endif

  always_ff @(posedge PixelClk) begin
    if (!nRST) rgb_reg <= 16'd0;
    else       rgb_reg <= pre_de ? rgb_src : 16'd0;
  end

  assign LCD_DE    = tap_out.de;
  assign LCD_HSYNC = tap_out.hs;
  assign LCD_VSYNC = tap_out.vs;
  assign LCD_R     = rgb_reg[15:11];
  assign LCD_G     = rgb_reg[10:5];
  assign LCD_B     = rgb_reg[4:0];

endmodule
